// File: rtl/pipeline_hazard_controller.sv
// Hazard/halt controller: load-use bubbles, JB redirect flushes, debug drain-and-halt; optional perf counters via HAZARD_PERF_CNT_EN.
// Latency: control outputs are combinational from state and current inputs; state and counters update on the rising edge.
// Backpressure: no handshake; pc_stall/if_id_stall freeze the front end, flushes insert bubbles.
module pipeline_hazard_controller #(
    parameter int CNT_WIDTH    = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           jb_rd,
    input  logic                 jb_memread,
    input  logic                 jb_redirect,
    input  logic                 halt_req,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 if_id_flush,
    output logic                 id_jb_flush,
    output logic                 halted,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_t        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          load_use;
    logic          stall_c, flush_c, bubble_c, halted_c;

    assign load_use = jb_memread && (jb_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == jb_rd)) ||
                       (id_uses_rs2 && (id_rs2 == jb_rd)));

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        bubble_c = 1'b0;
        halted_c = 1'b0;
        case (state_q)
            RUN: begin
                if (jb_redirect) begin
                    flush_c = 1'b1;
                    state_d = REDIRECT;
                end else begin
                    if (load_use) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                    end
                    if (halt_req) begin
                        state_d = DRAIN;
                        drain_d = DW'(DRAIN_CYCLES);
                    end
                end
            end
            REDIRECT: begin
                // The fetch registered before the redirect is stale; flush it once more.
                flush_c = 1'b1;
                if (!jb_redirect) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (jb_redirect) begin
                    flush_c = 1'b1;
                end else begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end
                if (drain_q != '0) begin
                    drain_d = drain_q - DW'(1);
                end
                if (drain_q <= DW'(1)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                halted_c = 1'b1;
                if (drain_q != '0) begin
                    drain_d = drain_q - DW'(1);
                end
                if (!halt_req) begin
                    state_d = REDIRECT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Reset overrides the FSM so the pipeline registers are held flushed.
    assign pc_stall    = reset_n & stall_c;
    assign if_id_stall = reset_n & stall_c;
    assign if_id_flush = ~reset_n | flush_c;
    assign id_jb_flush = ~reset_n | flush_c | bubble_c;
    assign halted      = reset_n & halted_c;
    assign state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_stall && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_WIDTH'(1);
            end
            if (if_id_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized + directed bench for pipeline_hazard_controller against a cycle-level reference model.
module tb_pipeline_hazard_controller;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int NDRAIN = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs1, id_rs2, jb_rd;
    logic        id_uses_rs1, id_uses_rs2, jb_memread, jb_redirect, halt_req;
    logic        pc_stall, if_id_stall, if_id_flush, id_jb_flush, halted;
    logic [1:0]  state;
    logic [31:0] stall_cycles, flush_cycles;

    pipeline_hazard_controller #(.CNT_WIDTH(32), .DRAIN_CYCLES(NDRAIN)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .jb_rd(jb_rd), .jb_memread(jb_memread),
        .jb_redirect(jb_redirect), .halt_req(halt_req),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_jb_flush(id_jb_flush),
        .halted(halted), .state(state),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: mode 0=run, 1=post-redirect, 2=draining, 3=halted.
    int          m_mode = 0;
    int          m_left = 0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_flush = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_ctl(input int mode, input logic redir, input logic lu);
        logic redir_live, frozen, stall, flush;
        redir_live = redir && (mode != 3);
        frozen     = (mode == 2) || (mode == 3);
        stall      = !redir_live && (frozen || (mode == 0 && lu));
        flush      = redir_live || (mode == 1);
        // {pc_stall, if_id_stall, if_id_flush, id_jb_flush, halted}
        return {stall, stall, flush, flush || stall, mode == 3};
    endfunction

    task automatic step(input logic redir, input logic halt, input logic mr,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2);
        logic       lu;
        logic [4:0] e;
        @(negedge clk);
        jb_redirect = redir; halt_req = halt; jb_memread = mr; jb_rd = rd;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        #1;
        lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e  = model_ctl(m_mode, redir, lu);
        chk("ctl", {pc_stall, if_id_stall, if_id_flush, id_jb_flush, halted}, {27'd0, e});
        chk("state", {30'd0, state}, m_mode);
        chk("stall_cnt", stall_cycles, PERF ? m_stall : 32'd0);
        chk("flush_cnt", flush_cycles, PERF ? m_flush : 32'd0);
        @(posedge clk);
        if (e[4] && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (e[2] && m_flush != 32'hFFFF_FFFF) m_flush++;
        case (m_mode)
            0: if (redir) m_mode = 1;
               else if (halt) begin m_mode = 2; m_left = NDRAIN; end
            1: if (!redir) m_mode = 0;
            2: begin
                if (m_left <= 1) m_mode = 3;
                if (m_left > 0) m_left--;
            end
            default: if (!halt) m_mode = 1;
        endcase
    endtask

    task automatic idle(input logic halt);
        step(1'b0, halt, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        jb_redirect = 0; halt_req = 0; jb_memread = 0; jb_rd = 0;
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ctl", {pc_stall, if_id_stall, if_id_flush, id_jb_flush, halted}, 32'b00110);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_stall_cnt", stall_cycles, 32'd0);
        chk("rst_flush_cnt", flush_cycles, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    endtask

    initial begin
        logic h;
        reset_n = 1'b0;
        jb_redirect = 0; halt_req = 0; jb_memread = 0; jb_rd = 0;
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        do_reset();

        // Load-use bubble on rs1.
        step(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0);
        idle(1'b0);
        #1 chk("lu_stall_cnt", stall_cycles, PERF ? 32'd1 : 32'd0);

        // Loads that are not hazards: x0 destination, unused source.
        step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0);
        #1 chk("nohaz_stall", {31'd0, pc_stall}, 32'd0);

        // Redirect overriding a load-use hazard.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b0);
        #1 chk("redir_flush_cnt", flush_cycles, PERF ? 32'd2 : 32'd0);

        // Halt, drain, resume through one redirect cycle.
        do_reset();
        repeat (NDRAIN + 3) idle(1'b1);
        #1 chk("halt_halted", {31'd0, halted}, 32'd1);
        idle(1'b0);
        idle(1'b0);
        #1 chk("resume_state", {30'd0, state}, 32'd0);

        // Redirect in the first drain cycle; halt still lands on time.
        do_reset();
        idle(1'b1);
        step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (NDRAIN - 1) idle(1'b1);
        #1 chk("drain_redir_halted", {31'd0, halted}, 32'd1);

        // Redirect ignored while halted, then reset while halted.
        step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        do_reset();

        // Random traffic with a held, occasionally toggling halt request.
        h = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            if ($urandom_range(0, 24) == 0) h = ~h;
            step($urandom_range(0, 7) == 0, h, 1'($urandom),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
Parameters:
REQ-001 SHALL have parameter CNT_WIDTH, default 32: width of the performance counters.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4: number of bubble cycles needed to empty JB, EX, MEM and WB before halt.

Ports:
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, 5 each: source register numbers of the instruction in ID.
REQ-006 SHALL have ports id_uses_rs1 and id_uses_rs2, input, 1 each: the ID instruction actually reads that source.
REQ-007 SHALL have ports jb_rd (input, 5) and jb_memread (input, 1): destination register and load flag of the instruction in JB.
REQ-008 SHALL have port jb_redirect, input, 1: a taken branch or jump resolved in JB this cycle.
REQ-009 SHALL have port halt_req, input, 1: level-sensitive debug halt request.
REQ-010 SHALL have ports pc_stall, if_id_stall, if_id_flush and id_jb_flush, output, 1 each: pipeline-register controls.
REQ-011 SHALL have port halted, output, 1: pipeline fully drained and frozen.
REQ-012 SHALL have port state, output, 2: current FSM state (RUN=0, REDIRECT=1, DRAIN=2, HALTED=3).
REQ-013 SHALL have ports stall_cycles and flush_cycles, output, CNT_WIDTH each: performance counters.

Function
REQ-014 SHALL compute load_use = jb_memread & (jb_rd!=0) & ((id_uses_rs1 & id_rs1==jb_rd) | (id_uses_rs2 & id_rs2==jb_rd)).
REQ-015 SHALL drive all control outputs combinationally from state and the current inputs, with zero-cycle latency.
REQ-016 In RUN with no event: all stall/flush outputs SHALL be 0.
REQ-017 In RUN with load_use=1 and jb_redirect=0: pc_stall=1, if_id_stall=1, id_jb_flush=1 for exactly one cycle (one bubble); state SHALL stay RUN.
REQ-018 On jb_redirect=1 in any state except HALTED: if_id_flush=1, id_jb_flush=1, pc_stall=0; redirect SHALL override load_use and drain stalls.
REQ-019 On jb_redirect=1, RUN or REDIRECT SHALL go to REDIRECT; DRAIN SHALL stay in DRAIN.
REQ-020 REDIRECT with jb_redirect=0: if_id_flush=1, id_jb_flush=1, stalls 0, to discard the stale registered fetch; next state RUN.
REQ-021 halt_req SHALL be sampled only in RUN with jb_redirect=0; on halt_req, next state DRAIN and the drain counter loads DRAIN_CYCLES.
REQ-022 halt_req together with load_use SHALL enter DRAIN; drain bubbles cover the load-use bubble.
REQ-023 DRAIN and HALTED: pc_stall=1, if_id_stall=1, id_jb_flush=1 (unless REQ-018 applies); the drain counter decrements each cycle.
REQ-024 DRAIN SHALL go to HALTED on the cycle the counter equals 1; halted=1 only in HALTED.
REQ-025 jb_redirect SHALL be ignored in HALTED.
REQ-026 HALTED with halt_req=0 SHALL go to REDIRECT (one flush cycle), then RUN.
REQ-027 stall_cycles SHALL increment on each cycle with pc_stall=1; flush_cycles SHALL increment on each cycle with if_id_flush=1; both counters saturate at all-ones.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state=RUN, drain counter=0, and counters=0.
REQ-029 While reset_n=0, outputs SHALL be if_id_flush=1, id_jb_flush=1, pc_stall=0, if_id_stall=0, halted=0.
REQ-030 Reset asserted mid-DRAIN or in HALTED SHALL abandon the halt; after release the block starts in RUN.

Configuration
REQ-031 Macro HAZARD_PERF_CNT_EN SHALL control the performance counters.
REQ-032 With HAZARD_PERF_CNT_EN defined, counters SHALL behave per REQ-027.
REQ-033 With HAZARD_PERF_CNT_EN undefined, stall_cycles and flush_cycles SHALL be constant 0, with no counter flops.

Verification
REQ-034 Load-use test: jb_memread=1, jb_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle of pc_stall=1, if_id_stall=1, id_jb_flush=1; stall_cycles becomes 1.
REQ-035 Load with no hazard: jb_rd=0 with id_rs1=0, or id_uses_rs1=0 -> no stall.
REQ-036 Redirect with load-use: jb_redirect=1 and load_use=1 together -> pc_stall=0, both flushes 1, then one REDIRECT cycle, then RUN; flush_cycles=2.
REQ-037 Halt test: halt_req held 1 in RUN -> 4 DRAIN cycles, then halted=1; deassert halt_req -> one REDIRECT cycle, then RUN.
REQ-038 Redirect during DRAIN: jb_redirect=1 in the first DRAIN cycle -> pc_stall=0, flushes 1, state stays DRAIN; halted=1 after 4 cycles total.
REQ-039 Reset in HALTED: reset_n=0 -> state=0, halted=0, counters 0 immediately, without waiting for a clock edge.
